// File: rtl/reg_file.sv
// reg_file: 31 x XLEN general-purpose register file with two write-through
// read ports, a retired-write counter and a three-state debug read port.
module reg_file #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             RegWrite,
    input  logic [4:0]       rd_addr,
    input  logic [XLEN-1:0]  rd_data,
    input  logic [4:0]       rs1_addr,
    output logic [XLEN-1:0]  rs1_data,
    input  logic [4:0]       rs2_addr,
    output logic [XLEN-1:0]  rs2_data,
    input  logic             dbg_req,
    input  logic [4:0]       dbg_addr,
    output logic             dbg_ack,
    output logic [XLEN-1:0]  dbg_data,
    output logic             dbg_busy,
    output logic [CNT_W-1:0] wr_count
);

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_READ = 2'b01;
    localparam logic [1:0] ST_RESP = 2'b10;

    // x0 has no storage; it is hard-wired to zero in the read path.
    logic [XLEN-1:0]  regs_q [1:31];
    logic [XLEN-1:0]  regs_d [1:31];
    logic [CNT_W-1:0] wr_count_q, wr_count_d;
    logic [1:0]       state_q, state_d;
    logic [4:0]       dbg_addr_q, dbg_addr_d;
    logic [XLEN-1:0]  dbg_data_q, dbg_data_d;
    logic             wr_en;

    // A write to x0 is architecturally a no-op and is not counted.
    assign wr_en = RegWrite && (rd_addr != 5'd0);

    // Write-through read: a same-cycle write to the addressed register wins
    // over the stored value, so a dependent instruction sees it immediately.
    function automatic logic [XLEN-1:0] read_wt(input logic [4:0] addr);
        if (addr == 5'd0) begin
            return '0;
        end else if (wr_en && (rd_addr == addr)) begin
            return rd_data;
        end else begin
            return regs_q[addr];
        end
    endfunction

    // Combinational read ports, each independently bypassed.
    always_comb begin
        rs1_data = read_wt(rs1_addr);
        rs2_data = read_wt(rs2_addr);
    end

    // Next-state of storage and the retired-write counter.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        regs_d     = regs_q;
        wr_count_d = wr_count_q;
        if (wr_en) begin
            regs_d[rd_addr] = rd_data;
            wr_count_d      = wr_count_q + CNT_W'(1);
        end
    end

    // Debug FSM: accept in IDLE, sample the register in READ, pulse ack in RESP.
    always_comb begin
        state_d    = state_q;
        dbg_addr_d = dbg_addr_q;
        dbg_data_d = dbg_data_q;
        case (state_q)
            ST_IDLE: begin
                if (dbg_req) begin
                    dbg_addr_d = dbg_addr;
                    state_d    = ST_READ;
                end
            end
            ST_READ: begin
                dbg_data_d = read_wt(dbg_addr_q);
                state_d    = ST_RESP;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset; a write in the reset cycle is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the register array is cleared on reset because software
            // relies on every register reading zero after reset; this is why
            // storage is flops rather than a RAM macro.
            for (int i = 1; i < 32; i++) begin
                regs_q[i] <= '0;
            end
            wr_count_q <= '0;
            state_q    <= ST_IDLE;
            dbg_addr_q <= '0;
            dbg_data_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // values that existed before this edge.
            regs_q     <= regs_d;
            wr_count_q <= wr_count_d;
            state_q    <= state_d;
            dbg_addr_q <= dbg_addr_d;
            dbg_data_q <= dbg_data_d;
        end
    end

    assign dbg_ack  = (state_q == ST_RESP);
    assign dbg_busy = (state_q != ST_IDLE);
    assign dbg_data = dbg_data_q;
    assign wr_count = wr_count_q;

endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: directed scenarios plus randomized traffic for reg_file,
// checked every cycle against a behavioural register-file model.
module tb_reg_file;

    localparam int XLEN  = 32;
    localparam int CNT_W = 4;

    logic             clk;
    logic             rst;
    logic             RegWrite;
    logic [4:0]       rd_addr;
    logic [XLEN-1:0]  rd_data;
    logic [4:0]       rs1_addr;
    logic [XLEN-1:0]  rs1_data;
    logic [4:0]       rs2_addr;
    logic [XLEN-1:0]  rs2_data;
    logic             dbg_req;
    logic [4:0]       dbg_addr;
    logic             dbg_ack;
    logic [XLEN-1:0]  dbg_data;
    logic             dbg_busy;
    logic [CNT_W-1:0] wr_count;

    int n_checks = 0;
    int n_fail   = 0;

    reg_file #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .RegWrite (RegWrite),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rs1_addr (rs1_addr),
        .rs1_data (rs1_data),
        .rs2_addr (rs2_addr),
        .rs2_data (rs2_data),
        .dbg_req  (dbg_req),
        .dbg_addr (dbg_addr),
        .dbg_ack  (dbg_ack),
        .dbg_data (dbg_data),
        .dbg_busy (dbg_busy),
        .wr_count (wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [XLEN-1:0]  m_mem [0:31];
    logic [CNT_W-1:0] m_cnt;
    logic [XLEN-1:0]  m_dbg_data;
    logic [4:0]       m_dbg_addr;
    bit               m_pend;
    int               m_acc;
    int               edge_n = 0;
    bit               model_valid = 1'b0;

    function automatic logic [XLEN-1:0] m_wt(input logic [4:0] a);
        if (a == 5'd0) return '0;
        if (RegWrite && rd_addr != 5'd0 && rd_addr == a) return rd_data;
        return m_mem[a];
    endfunction

    // Model update: edge number edge_n; a request accepted at edge k samples
    // its register at edge k+1 and is acknowledged in the cycle after that.
    always @(posedge clk) begin
        edge_n <= edge_n + 1;
        if (rst) begin
            for (int i = 0; i < 32; i++) m_mem[i] <= '0;
            m_cnt       <= '0;
            m_dbg_data  <= '0;
            m_dbg_addr  <= '0;
            m_pend      <= 1'b0;
            m_acc       <= -10;
            model_valid <= 1'b1;
        end else begin
            if (RegWrite && rd_addr != 5'd0) begin
                m_mem[rd_addr] <= rd_data;
                m_cnt          <= m_cnt + 1'b1;
            end
            if (m_pend) begin
                if (edge_n == m_acc + 1) m_dbg_data <= m_wt(m_dbg_addr);
                if (edge_n == m_acc + 2) m_pend <= 1'b0;
            end else if (dbg_req) begin
                m_pend     <= 1'b1;
                m_acc      <= edge_n;
                m_dbg_addr <= dbg_addr;
            end
        end
    end

    // Compare process: every settled cycle once the model has seen a reset.
    always @(negedge clk) begin
        if (model_valid) begin
            check("rs1_data", rs1_data, m_wt(rs1_addr));
            check("rs2_data", rs2_data, m_wt(rs2_addr));
            check("wr_count", wr_count, m_cnt);
            check("dbg_busy", dbg_busy, m_pend);
            check("dbg_ack",  dbg_ack,  m_pend && (edge_n == m_acc + 2));
            check("dbg_data", dbg_data, m_dbg_data);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1; RegWrite = 1'b0; rd_addr = '0; rd_data = '0;
        rs1_addr = '0; rs2_addr = '0; dbg_req = 1'b0; dbg_addr = '0;
        cyc(); cyc();
        rst = 1'b0;

        // Reset state
        rs1_addr = 5'd17; rs2_addr = 5'd31;
        at_neg();
        check("rst_rs1", rs1_data, 32'h0);
        check("rst_rs2", rs2_data, 32'h0);
        check("rst_cnt", wr_count, 4'd0);
        check("rst_busy", dbg_busy, 1'b0);
        check("rst_dbg_data", dbg_data, 32'h0);
        cyc();

        // Write then read on both ports
        RegWrite = 1'b1; rd_addr = 5'd5; rd_data = 32'hDEADBEEF;
        cyc();
        RegWrite = 1'b0; rs1_addr = 5'd5; rs2_addr = 5'd5;
        at_neg();
        check("x5_rs1", rs1_data, 32'hDEADBEEF);
        check("x5_rs2", rs2_data, 32'hDEADBEEF);
        check("x5_cnt", wr_count, 4'd1);
        cyc();

        // Same-cycle bypass
        RegWrite = 1'b1; rd_addr = 5'd7; rd_data = 32'h1234; rs1_addr = 5'd7;
        at_neg();
        check("bypass_rs1", rs1_data, 32'h1234);
        cyc();
        RegWrite = 1'b0;
        at_neg();
        check("x7_stored", rs1_data, 32'h1234);
        check("x7_cnt", wr_count, 4'd2);
        cyc();

        // Write to x0 is discarded
        RegWrite = 1'b1; rd_addr = 5'd0; rd_data = 32'hFFFFFFFF; rs2_addr = 5'd0;
        at_neg();
        check("x0_same", rs2_data, 32'h0);
        cyc();
        RegWrite = 1'b0;
        at_neg();
        check("x0_after", rs2_data, 32'h0);
        check("x0_cnt", wr_count, 4'd2);
        cyc();

        // Debug read with a second request while busy
        RegWrite = 1'b1; rd_addr = 5'd3; rd_data = 32'hA5;
        cyc();
        RegWrite = 1'b0; dbg_req = 1'b1; dbg_addr = 5'd3;
        cyc();
        dbg_addr = 5'd9;
        at_neg();
        check("dbg_busy_read", dbg_busy, 1'b1);
        check("dbg_ack_read", dbg_ack, 1'b0);
        cyc();
        dbg_req = 1'b0;
        at_neg();
        check("dbg_ack_resp", dbg_ack, 1'b1);
        check("dbg_data_resp", dbg_data, 32'hA5);
        cyc();
        at_neg();
        check("dbg_ack_done", dbg_ack, 1'b0);
        check("dbg_busy_done", dbg_busy, 1'b0);
        check("dbg_data_hold", dbg_data, 32'hA5);
        cyc();

        // Reset while in READ after three writes
        dbg_req = 1'b1; dbg_addr = 5'd5;
        cyc();
        dbg_req = 1'b0; rst = 1'b1;
        cyc();
        rst = 1'b0; rs1_addr = 5'd5; rs2_addr = 5'd3;
        dbg_req = 1'b1; dbg_addr = 5'd7;
        at_neg();
        check("abort_ack", dbg_ack, 1'b0);
        check("abort_busy", dbg_busy, 1'b0);
        check("abort_cnt", wr_count, 4'd0);
        check("abort_rs1", rs1_data, 32'h0);
        check("abort_rs2", rs2_data, 32'h0);
        check("abort_dbg_data", dbg_data, 32'h0);
        cyc();
        dbg_req = 1'b0;
        at_neg();
        check("post_rst_accept", dbg_busy, 1'b1);
        cyc();
        at_neg();
        check("post_rst_ack", dbg_ack, 1'b1);
        check("post_rst_data", dbg_data, 32'h0);
        cyc();

        // Counter wrap: 17 writes into a 4-bit counter
        for (int i = 1; i <= 17; i++) begin
            RegWrite = 1'b1; rd_addr = 5'((i % 31) + 1); rd_data = 32'(i);
            cyc();
        end
        RegWrite = 1'b0;
        at_neg();
        check("wrap_cnt", wr_count, 4'd1);
        cyc();

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            rst      = ($urandom_range(0, 63) == 0);
            RegWrite = $urandom_range(0, 1);
            rd_addr  = 5'($urandom_range(0, 31));
            rd_data  = $urandom;
            rs1_addr = ($urandom_range(0, 3) == 0) ? rd_addr : 5'($urandom_range(0, 31));
            rs2_addr = ($urandom_range(0, 3) == 0) ? rs1_addr : 5'($urandom_range(0, 31));
            dbg_req  = ($urandom_range(0, 3) == 0);
            dbg_addr = ($urandom_range(0, 3) == 0) ? rd_addr : 5'($urandom_range(0, 31));
            cyc();
        end
        rst = 1'b0; RegWrite = 1'b0; dbg_req = 1'b0;
        cyc();
        at_neg();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
